// File: rtl/md5_sweep_scheduler.sv
// md5_sweep_scheduler: feeds LANES-wide candidate blocks over a range to MD5 pipelines and resolves matches via a tag line.
// Optional RUNNING/DRAIN cycle counter on run_cycles when MD5_SWEEP_CYCLE_COUNT_EN is defined.
module md5_sweep_scheduler #(
    parameter int LANES     = 8,
    parameter int LANE_BITS = 3,
    parameter int CNT_WIDTH = 32,
    parameter int LATENCY   = 64
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 enable_switch,
    input  logic                 restart,
    input  logic [CNT_WIDTH-1:0] range_start,
    input  logic [CNT_WIDTH-1:0] range_end,
    input  logic [LANES-1:0]     found_vec,
    output logic [CNT_WIDTH-1:0] cand_base,
    output logic                 status_paused,
    output logic                 status_running,
    output logic                 status_warming,
    output logic                 status_found,
    output logic                 status_done,
    output logic [CNT_WIDTH-1:0] found_value,
    output logic [LANE_BITS-1:0] found_lane,
    output logic [31:0]          run_cycles
);
    localparam int HW = CNT_WIDTH - LANE_BITS;
    localparam int CW = $clog2(LATENCY);
    typedef enum logic [2:0] {
        IDLE, WARMUP, WARMUP_PAUSED, RUNNING, RUNNING_PAUSED, DRAIN, FOUND, NOT_FOUND
    } state_t;
    state_t               state_q;
    logic [HW-1:0]        base_q, end_q;
    logic [CW-1:0]        cnt_q;
    logic [CNT_WIDTH-1:0] found_value_q;
    logic [LANE_BITS-1:0] found_lane_q, lane_d;
    logic [LATENCY-1:0]   tag_v_q;
    logic [HW-1:0]        tag_b_q [LATENCY];
    logic [LANES-1:0]     hit_vec_d;
    logic                 hit_d, push_d, terminal_d;
    logic                 unused_lsb;
    assign unused_lsb = ^{range_start[LANE_BITS-1:0], range_end[LANE_BITS-1:0]};
    // Only the block index is tracked; lane bits are implied by position in found_vec.
    always_comb begin
        push_d = state_q == RUNNING || state_q == RUNNING_PAUSED;
        terminal_d = state_q == FOUND || state_q == NOT_FOUND;
        hit_vec_d = (tag_v_q[LATENCY-1] && (push_d || state_q == DRAIN)) ? found_vec : '0;
        hit_d = |hit_vec_d;
        lane_d = '0;
        for (int i = LANES - 1; i >= 0; i--) lane_d = hit_vec_d[i] ? LANE_BITS'(i) : lane_d;
    end
    always_ff @(posedge CLK) begin
        tag_v_q <= (reset || (restart && terminal_d)) ? '0 : {tag_v_q[LATENCY-2:0], push_d};
        tag_b_q[0] <= base_q;
        for (int i = 1; i < LATENCY; i++) tag_b_q[i] <= tag_b_q[i-1];
    end
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            base_q <= '0;
            end_q <= '0;
            cnt_q <= '0;
            found_value_q <= '0;
            found_lane_q <= '0;
        end else if (hit_d) begin
            state_q <= FOUND;
            found_lane_q <= lane_d;
            found_value_q <= {tag_b_q[LATENCY-1], lane_d};
        end else begin
            case (state_q)
                IDLE: if (enable_switch) begin
                    state_q <= WARMUP;
                    base_q <= range_start[CNT_WIDTH-1:LANE_BITS];
                    end_q <= range_end[CNT_WIDTH-1:LANE_BITS];
                    cnt_q <= '0;
                    found_value_q <= '0;
                    found_lane_q <= '0;
                end
                WARMUP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(LATENCY - 2)) state_q <= RUNNING;
                    else if (!enable_switch) state_q <= WARMUP_PAUSED;
                end
                WARMUP_PAUSED: if (enable_switch) state_q <= WARMUP;
                RUNNING: begin
                    if (base_q == end_q) begin
                        state_q <= DRAIN;
                        cnt_q <= '0;
                    end else if (!enable_switch) state_q <= RUNNING_PAUSED;
                    else base_q <= base_q + 1'b1;
                end
                RUNNING_PAUSED: if (enable_switch) state_q <= RUNNING;
                DRAIN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(LATENCY - 1)) state_q <= NOT_FOUND;
                end
                default: if (restart) state_q <= IDLE;
            endcase
        end
    end
`ifdef MD5_SWEEP_CYCLE_COUNT_EN
    logic [31:0] run_q;
    always_ff @(posedge CLK) begin
        if (reset || (state_q == IDLE && enable_switch)) run_q <= '0;
        else if ((state_q == RUNNING || state_q == DRAIN) && run_q != '1) run_q <= run_q + 1'b1;
    end
    assign run_cycles = run_q;
`else
    assign run_cycles = '0;
`endif
    assign cand_base = {base_q, LANE_BITS'(0)};
    assign found_value = found_value_q;
    assign found_lane = found_lane_q;
    assign status_paused = state_q inside {IDLE, WARMUP_PAUSED, RUNNING_PAUSED};
    assign status_running = state_q inside {WARMUP, WARMUP_PAUSED, RUNNING, RUNNING_PAUSED, DRAIN};
    assign status_warming = state_q inside {WARMUP, WARMUP_PAUSED};
    assign status_found = state_q == FOUND;
    assign status_done = terminal_d;
endmodule
